// File: rtl/seq_pattern_det.sv
// rtl/seq_pattern_det.sv - serial pattern detector with programmable pattern/mask and hit counter
//
// Optional feature macro: SEQDET_CLR_EN (adds hit_clr, a synchronous clear of hit_count).
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_valid, w     serial sample strobe and data bit
//   cfg_load        latch cfg_pattern / cfg_mask / cfg_overlap, restart the sequence
//   cfg_pattern     target pattern, bit PAT_W-1 = oldest sample, bit 0 = newest
//   cfg_mask        1 = compare bit, 0 = don't care
//   cfg_overlap     1 = overlapping matches allowed
//   hit_clr         clear hit_count (SEQDET_CLR_EN only)
//   z               registered one-cycle match pulse
//   armed           history holds PAT_W valid samples
//   hit_count       saturating match count

module seq_pattern_det #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             w,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
`ifdef SEQDET_CLR_EN
    input  logic             hit_clr,
`endif
    output logic             z,
    output logic             armed,
    output logic [CNT_W-1:0] hit_count
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pat;
    logic [PAT_W-1:0]  msk;
    logic              ovl;

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    logic              accept;
    logic              match;
    logic              clr;

`ifdef SEQDET_CLR_EN
    assign clr = hit_clr;
`else
    assign clr = 1'b0;
`endif

    // cfg_load outranks a sample presented in the same cycle, so the sample is dropped.
    assign accept = in_valid & ~cfg_load;

    always_comb begin
        hist_n = {hist[PAT_W-2:0], w};
        fill_n = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        match  = accept && (fill_n == FILL_FULL) && (((hist_n ^ pat) & msk) == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
            pat  <= '0;
            msk  <= '1;
            ovl  <= 1'b1;
            z    <= 1'b0;
        end else if (cfg_load) begin
            pat  <= cfg_pattern;
            msk  <= cfg_mask;
            ovl  <= cfg_overlap;
            fill <= '0;
            z    <= 1'b0;
        end else if (in_valid) begin
            hist <= hist_n;
            z    <= match;
            // Non-overlapping mode consumes the matched bits by restarting the fill.
            fill <= (match && !ovl) ? '0 : fill_n;
        end else begin
            z <= 1'b0;
        end
    end

    // The clear wins over a simultaneous increment; z is unaffected by it.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hit_count <= '0;
        end else if (match && hit_count != CNT_MAX) begin
            hit_count <= hit_count + CNT_W'(1);
        end
    end

    assign armed = (fill == FILL_FULL);

endmodule

// File: tb/tb_seq_pattern_det.sv
// tb/tb_seq_pattern_det.sv - directed self-checking bench for seq_pattern_det
module tb_seq_pattern_det;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       w = 1'b0;
    logic       cfg_load = 1'b0;
    logic [3:0] cfg_pattern = '0;
    logic [3:0] cfg_mask = '1;
    logic       cfg_overlap = 1'b1;
    logic       hit_clr = 1'b0;

    logic       z, armed;
    logic [7:0] hit_count;
    logic       z2, armed2;
    logic [1:0] hit_count2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_pattern_det #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .w(w),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap),
`ifdef SEQDET_CLR_EN
        .hit_clr(hit_clr),
`endif
        .z(z), .armed(armed), .hit_count(hit_count)
    );

    seq_pattern_det #(.PAT_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .w(w),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap),
`ifdef SEQDET_CLR_EN
        .hit_clr(1'b0),
`endif
        .z(z2), .armed(armed2), .hit_count(hit_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge; inputs change there too.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic b);
        in_valid = 1'b1;
        w = b;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load(input logic [3:0] p, input logic [3:0] m, input logic o);
        cfg_load = 1'b1;
        cfg_pattern = p;
        cfg_mask = m;
        cfg_overlap = o;
        cycle();
        cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    // Feeds n back-to-back samples (bits[0] first) and checks z after each one.
    task automatic run_seq(input string tag, input logic [15:0] bits,
                           input logic [15:0] zexp, input int n);
        for (int i = 0; i < n; i++) begin
            sample(bits[i]);
            check($sformatf("%s_z%0d", tag, i), {31'd0, z}, {31'd0, zexp[i]});
        end
    endtask

    initial begin
        // Reset state
        cycle();
        check("rst_z", {31'd0, z}, 32'd0);
        check("rst_armed", {31'd0, armed}, 32'd0);
        check("rst_cnt", {24'd0, hit_count}, 32'd0);
        reset = 1'b0;

        // 1. Basic match 1101
        load(4'b1101, 4'b1111, 1'b1);
        sample(1'b1);
        sample(1'b1);
        sample(1'b0);
        check("t1_z3", {31'd0, z}, 32'd0);
        check("t1_armed3", {31'd0, armed}, 32'd0);
        sample(1'b1);
        check("t1_z4", {31'd0, z}, 32'd1);
        check("t1_armed4", {31'd0, armed}, 32'd1);
        check("t1_cnt", {24'd0, hit_count}, 32'd1);
        idle(1);
        check("t1_z_idle", {31'd0, z}, 32'd0);

        // 2. Overlap on / off, stream 1,0,1,1,0,1,1 (bit0 first)
        load(4'b1011, 4'b1111, 1'b1);
        run_seq("t2_ovl", 16'b1101101, 16'b1001000, 7);
        check("t2_ovl_cnt", {24'd0, hit_count}, 32'd3);
        load(4'b1011, 4'b1111, 1'b0);
        sample(1'b1);
        sample(1'b0);
        sample(1'b1);
        sample(1'b1);
        check("t2_novl_z4", {31'd0, z}, 32'd1);
        check("t2_novl_armed4", {31'd0, armed}, 32'd0);
        run_seq("t2_novl", 16'b110, 16'b000, 3);
        check("t2_novl_cnt", {24'd0, hit_count}, 32'd4);

        // 3. Idle gaps with mask 1001
        load(4'b1001, 4'b1001, 1'b1);
        sample(1'b1); check("t3_za", {31'd0, z}, 32'd0); idle(3);
        sample(1'b0); check("t3_zb", {31'd0, z}, 32'd0); idle(3);
        sample(1'b0); check("t3_zc", {31'd0, z}, 32'd0); idle(3);
        sample(1'b1); check("t3_zd", {31'd0, z}, 32'd1);
        idle(1);
        check("t3_z_gap", {31'd0, z}, 32'd0);
        load(4'b1001, 4'b1001, 1'b1);
        run_seq("t3_ones", 16'b1111, 16'b1000, 4);
        check("t3_cnt", {24'd0, hit_count}, 32'd6);

        // 4. Saturation on the CNT_W=2 instance, eight consecutive 1s
        do_reset();
        load(4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) begin
            sample(1'b1);
            check($sformatf("t4_z2_%0d", i), {31'd0, z2}, (i >= 3) ? 32'd1 : 32'd0);
            check($sformatf("t4_cnt2_%0d", i), {30'd0, hit_count2},
                  (i < 3) ? 32'd0 : (i == 3) ? 32'd1 : (i == 4) ? 32'd2 : 32'd3);
        end
        check("t4_cnt8", {24'd0, hit_count}, 32'd5);
        idle(2);
        check("t4_cnt2_hold", {30'd0, hit_count2}, 32'd3);

        // 5a. cfg_load with a simultaneous valid sample drops that sample
        load(4'b1101, 4'b1111, 1'b1);
        sample(1'b1);
        sample(1'b1);
        sample(1'b0);
        cfg_load = 1'b1;
        in_valid = 1'b1;
        w = 1'b1;
        cycle();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        check("t5a_armed", {31'd0, armed}, 32'd0);
        check("t5a_z", {31'd0, z}, 32'd0);
        check("t5a_cnt", {24'd0, hit_count}, 32'd5);
        run_seq("t5a_after", 16'b101, 16'b000, 3);
        check("t5a_armed3", {31'd0, armed}, 32'd0);
        sample(1'b1);
        check("t5a_armed4", {31'd0, armed}, 32'd1);

        // 5b. Reset mid-sequence, then reset config (pat 0, mask all ones)
        sample(1'b0);
        sample(1'b0);
        sample(1'b0);
        do_reset();
        check("t5b_z", {31'd0, z}, 32'd0);
        check("t5b_armed", {31'd0, armed}, 32'd0);
        check("t5b_cnt", {24'd0, hit_count}, 32'd0);
        run_seq("t5b_three", 16'b000, 16'b000, 3);
        check("t5b_armed3", {31'd0, armed}, 32'd0);
        sample(1'b0);
        check("t5b_z4", {31'd0, z}, 32'd1);
        check("t5b_cnt4", {24'd0, hit_count}, 32'd1);

`ifdef SEQDET_CLR_EN
        // 6. hit_clr wins over a simultaneous match increment
        do_reset();
        load(4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) sample(1'b1);
        check("t6_cnt_pre", {24'd0, hit_count}, 32'd5);
        hit_clr = 1'b1;
        sample(1'b1);
        hit_clr = 1'b0;
        check("t6_z", {31'd0, z}, 32'd1);
        check("t6_cnt", {24'd0, hit_count}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
